// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit owning the HI/LO registers
// ports: clk; reset (async, active-low); A1/A2 operand buses; MDUOp+start command strobe;
//        HiLoSel read select; busy = op in flight; HI/LO registers; O = HiLoSel ? HI : LO
module mul_div_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic        HiLoSel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] O
);
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6;
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state;
  logic [31:0] cnt;
  logic [63:0] res, nxt, p_s, p_u;
  logic        wr, is_mul, is_div;
  logic [31:0] dvs, dvu, q_s, r_s, q_u, r_u;
  assign is_mul = MDUOp == OP_MULT || MDUOp == OP_MULTU;
  assign is_div = MDUOp == OP_DIV || MDUOp == OP_DIVU;
  // divisors forced to 1 where the real quotient is unused (by zero) or overflows:
  // -2^31 / -1 must give 0x80000000 rem 0, which is exactly -2^31 / 1
  assign dvs = (A2 == 32'd0 || (A1 == 32'h8000_0000 && A2 == 32'hFFFF_FFFF)) ? 32'd1 : A2;
  assign dvu = A2 == 32'd0 ? 32'd1 : A2;
  assign p_s = $signed({{32{A1[31]}}, A1}) * $signed({{32{A2[31]}}, A2});
  assign p_u = {32'd0, A1} * {32'd0, A2};
  assign q_s = $signed(A1) / $signed(dvs);
  assign r_s = $signed(A1) % $signed(dvs);
  assign q_u = A1 / dvu;
  assign r_u = A1 % dvu;
  assign nxt = MDUOp == OP_MULT ? p_s : MDUOp == OP_MULTU ? p_u : MDUOp == OP_DIV ? {r_s, q_s} : {r_u, q_u};
  assign O = HiLoSel ? HI : LO;
  // result is computed at the start edge and held until the latency counter expires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      res   <= '0;
      wr    <= 1'b0;
    end else if (state == IDLE) begin
      if (start && (is_mul || is_div)) begin
        state <= RUN;
        busy  <= 1'b1;
        cnt   <= is_mul ? 32'(MULT_LAT) : 32'(DIV_LAT);
        res   <= nxt;
        wr    <= !(is_div && A2 == 32'd0);
      end
      if (start && MDUOp == OP_MTHI) HI <= A1;
      if (start && MDUOp == OP_MTLO) LO <= A1;
    end else if (cnt == 32'd1) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      if (wr) begin
        HI <= res[63:32];
        LO <= res[31:0];
      end
    end else begin
      cnt <= cnt - 32'd1;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT = 10;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A1 = '0, A2 = '0;
  logic [3:0]  MDUOp = '0;
  logic        start = 1'b0, HiLoSel = 1'b0;
  logic        busy;
  logic [31:0] HI, LO, O;
  int          checks = 0, errors = 0;
  logic        chk_en = 1'b0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic        m_wr;
  int          m_rem;
  mul_div_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .MDUOp(MDUOp), .start(start),
    .HiLoSel(HiLoSel), .busy(busy), .HI(HI), .LO(LO), .O(O)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // architectural result {write_enable, HI, LO} from plain 64-bit arithmetic
  function automatic logic [64:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    if (op == 4'd1) return {1'b1, 64'(sa * sb)};
    if (op == 4'd2) return {1'b1, 64'(ua * ub)};
    if ((op == 4'd3 || op == 4'd4) && b == 32'd0) return 65'd0;
    if (op == 4'd3) return {1'b1, 32'(sa % sb), 32'(sa / sb)};
    if (op == 4'd4) return {1'b1, 32'(ua % ub), 32'(ua / ub)};
    return 65'd0;
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0;
      m_lo <= '0;
      m_rem <= 0;
      m_wr <= 1'b0;
      m_res <= '0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_wr) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end else if (start) begin
      if (MDUOp >= 4'd1 && MDUOp <= 4'd4) begin
        {m_wr, m_res} <= model(MDUOp, A1, A2);
        m_rem <= MDUOp <= 4'd2 ? MULT_LAT : DIV_LAT;
      end
      if (MDUOp == 4'd5) m_hi <= A1;
      if (MDUOp == 4'd6) m_lo <= A1;
    end
  end
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("cyc_busy", 32'(busy), 32'(m_rem > 0));
      chk("cyc_hi", HI, m_hi);
      chk("cyc_lo", LO, m_lo);
      chk("cyc_o", O, HiLoSel ? m_hi : m_lo);
    end
  end
  // issues one command; lat >= 0 checks the number of busy cycles; scr scrambles operands/HiLoSel while busy
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int lat, input bit scr);
    int n = 0;
    @(negedge clk);
    MDUOp = op; A1 = a; A2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = '0;
    while (busy && n < 100) begin
      n++;
      if (scr) begin
        A1 = $urandom;
        A2 = $urandom;
        HiLoSel = ~HiLoSel;
      end
      @(negedge clk);
    end
    if (lat >= 0) chk("busy_len", 32'(n), 32'(lat));
  endtask
  task automatic chk_hl(input string name, input logic [31:0] hi, input logic [31:0] lo);
    chk({name, "_hi"}, HI, hi);
    chk({name, "_lo"}, LO, lo);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    #12 reset = 1'b0;
    #1;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    HiLoSel = 1'b0;
    #1 chk("rst_o_lo", O, 32'd0);
    HiLoSel = 1'b1;
    #1 chk("rst_o_hi", O, 32'd0);
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, MULT_LAT, 0);
    chk_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, MULT_LAT, 0);
    chk_hl("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    HiLoSel = 1'b1;
    #1 chk("o_sel_hi", O, 32'h0000_0002);
    HiLoSel = 1'b0;
    #1 chk("o_sel_lo", O, 32'hFFFF_FFFA);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 0);
    chk_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4'd4, 32'd7, 32'd2, DIV_LAT, 0);
    chk_hl("divu", 32'd1, 32'd3);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 0);
    chk_hl("div_ovf", 32'd0, 32'h8000_0000);
    issue(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 0);
    chk_hl("divu_big", 32'h8000_0000, 32'd0);
    issue(4'd5, 32'h11, 32'd0, 0, 0);
    chk("mthi", HI, 32'h11);
    issue(4'd6, 32'h22, 32'd0, 0, 0);
    chk("mtlo", LO, 32'h22);
    issue(4'd7, 32'hDEAD_BEEF, 32'd1, 0, 0);
    chk_hl("undef_op", 32'h11, 32'h22);
    issue(4'd4, 32'd5, 32'd0, DIV_LAT, 0);
    chk_hl("divu_zero", 32'h11, 32'h22);
    @(negedge clk);
    MDUOp = 4'd4; A1 = 32'd9; A2 = 32'd4; start = 1'b1;
    @(negedge clk);
    MDUOp = 4'd6; A1 = 32'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = '0;
    repeat (DIV_LAT) @(negedge clk);
    chk("busy_done", 32'(busy), 32'd0);
    chk_hl("mtlo_ignored", 32'd1, 32'd2);
    @(negedge clk);
    MDUOp = 4'd1; A1 = 32'h1_0000; A2 = 32'h1_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk_hl("rst_mid", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (MULT_LAT + 2) @(negedge clk);
    chk_hl("no_late_wb", 32'd0, 32'd0);
    issue(4'd1, 32'd3, 32'd4, MULT_LAT, 0);
    chk_hl("mult_3x4", 32'd0, 32'd12);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, 1);
    chk_hl("stable", 32'hFFFF_FFFE, 32'h0000_0001);
    issue(4'd3, 32'd100, 32'hFFFF_FFF9, DIV_LAT, 1);
    chk_hl("stable_div", 32'd2, 32'hFFFF_FFF2);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
